// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with valid/ready
// handshakes on both sides and an OR-accumulate mode that reduces a burst of
// operands into a single result.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   flush_i      synchronous clear of pipeline, outputs and accumulator
//   in_valid_i   input beat valid
//   in_ready_o   input beat accepted when in_valid_i && in_ready_o
//   op_i         0 AND, 1 OR, 2 XOR, 3 NOR, 4 ANDN, 5 ORN, 6 XNOR, 7 ACC_OR
//   last_i       closes an ACC_OR burst (ignored for other ops)
//   a_i, b_i     operands (b_i ignored for ACC_OR)
//   out_valid_o  result valid
//   out_ready_i  result consumed when out_valid_o && out_ready_i
//   c_o          result
//   zero_o       c_o == 0
//   beats_o      beats reduced by an ACC_OR burst (saturating), 1 otherwise
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic             last_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] c_o,
    output logic             zero_o,
    output logic [CNT_W-1:0] beats_o
);

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_ANDN = 3'd4;
    localparam logic [OP_W-1:0] OP_ORN  = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
    localparam logic [OP_W-1:0] OP_ACC  = 3'd7;

    // Stage-1 payload captured on an accepted beat
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic             last;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } beat_t;

    // Pipeline and accumulator state
    logic             s1_valid;
    beat_t            s1;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    // Next-state values
    logic             s1_valid_d;
    beat_t            s1_d;
    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] cnt_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] c_d;
    logic             zero_d;
    logic [CNT_W-1:0] beats_d;

    // Handshake and datapath helpers
    logic             s2_can_load_c;
    logic             s2_load_c;
    logic             accept_c;
    logic [WIDTH-1:0] logic_res_c;
    logic [WIDTH-1:0] acc_sum_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // S2 can take a new result when the output slot is empty or draining
    assign s2_can_load_c = !out_valid_o || out_ready_i;
    assign s2_load_c     = s1_valid && s2_can_load_c;

    // Ready depends only on state and out_ready_i, never on in_valid_i
    assign in_ready_o    = !s1_valid || s2_can_load_c;

    // A beat presented together with flush is dropped
    assign accept_c      = in_valid_i && in_ready_o && !flush_i;

    // Bitwise result for the stage-1 beat
    always_comb begin
        logic_res_c = '0;
        case (s1.op)
            OP_AND:  logic_res_c = s1.a & s1.b;
            OP_OR:   logic_res_c = s1.a | s1.b;
            OP_XOR:  logic_res_c = s1.a ^ s1.b;
            OP_NOR:  logic_res_c = ~(s1.a | s1.b);
            OP_ANDN: logic_res_c = s1.a & ~s1.b;
            OP_ORN:  logic_res_c = s1.a | ~s1.b;
            OP_XNOR: logic_res_c = ~(s1.a ^ s1.b);
            OP_ACC:  logic_res_c = s1.a;
            default: logic_res_c = '0;
        endcase
    end

    // Accumulate candidates; the beat counter sticks at all-ones
    assign acc_sum_c = acc | s1.a;
    assign cnt_inc_c = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    // Next-state logic for both stages, outputs and accumulator
    always_comb begin
        s1_valid_d  = s1_valid;
        s1_d        = s1;
        acc_d       = acc;
        cnt_d       = cnt;
        out_valid_d = out_valid_o;
        c_d         = c_o;
        zero_d      = zero_o;
        beats_d     = beats_o;

        // Consumption empties the output slot unless refilled below
        if (out_valid_o && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        if (s2_load_c) begin
            if (s1.op == OP_ACC) begin
                if (s1.last) begin
                    // Closing beat publishes the burst and reopens empty
                    c_d         = acc_sum_c;
                    zero_d      = (acc_sum_c == '0);
                    beats_d     = cnt_inc_c;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                end else begin
                    // Interior beat folds into the accumulator, no output
                    acc_d = acc_sum_c;
                    cnt_d = cnt_inc_c;
                end
            end else begin
                c_d         = logic_res_c;
                zero_d      = (logic_res_c == '0);
                beats_d     = CNT_W'(1);
                out_valid_d = 1'b1;
            end
        end

        if (accept_c) begin
            s1_valid_d = 1'b1;
            s1_d.op    = op_i;
            s1_d.last  = last_i;
            s1_d.a     = a_i;
            s1_d.b     = b_i;
        end else if (s2_load_c) begin
            s1_valid_d = 1'b0;
        end

        // Flush overrides everything: back to the post-reset picture
        if (flush_i) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            c_d         = '0;
            zero_d      = 1'b1;
            beats_d     = '0;
            acc_d       = '0;
            cnt_d       = '0;
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid    <= 1'b0;
            s1          <= '0;
            acc         <= '0;
            cnt         <= '0;
            out_valid_o <= 1'b0;
            c_o         <= '0;
            zero_o      <= 1'b1;
            beats_o     <= '0;
        end else begin
            s1_valid    <= s1_valid_d;
            s1          <= s1_d;
            acc         <= acc_d;
            cnt         <= cnt_d;
            out_valid_o <= out_valid_d;
            c_o         <= c_d;
            zero_o      <= zero_d;
            beats_o     <= beats_d;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: self-checking bench for logic_unit_pipe (WIDTH=32,
// CNT_W=2). Expected results are queued when a beat is accepted and checked
// when the DUT hands a result over.
module tb_logic_unit_pipe;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             last;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             zero;
    logic [CNT_W-1:0] beats;

    logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .last_i      (last),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .c_o         (c),
        .zero_o      (zero),
        .beats_o     (beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] c;
        logic [CNT_W-1:0] beats;
        int               acc_cyc;
        bit               chk_lat;
    } exp_t;

    typedef struct {
        logic [2:0]       op;
        logic             last;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] ec;
        logic [CNT_W-1:0] eb;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Drive one beat and wait (bounded) for acceptance; queue its result
    task automatic send(input logic [2:0] op_v, input logic last_v,
                        input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                        input bit push, input logic [WIDTH-1:0] ec,
                        input logic [CNT_W-1:0] eb, input bit lat);
        bit   done = 1'b0;
        exp_t e;
        op       = op_v;
        last     = last_v;
        a        = a_v;
        b        = b_v;
        in_valid = 1'b1;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout op=%0d a=0x%0h", op_v, a_v);
        end else if (push) begin
            e.c       = ec;
            e.beats   = eb;
            e.acc_cyc = cyc;
            e.chk_lat = lat;
            sb.push_back(e);
        end
    endtask

    // Wait (bounded) until every queued result has been delivered
    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor / scoreboard
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=0x%0h required=none", c);
                end else begin
                    mon_e = sb.pop_front();
                    check("result_c", 64'(c), 64'(mon_e.c));
                    check("result_zero", 64'(zero), 64'(mon_e.c == '0));
                    check("result_beats", 64'(beats), 64'(mon_e.beats));
                    if (mon_e.chk_lat)
                        check("latency", 64'(cyc - mon_e.acc_cyc), 64'd1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl[10];

    initial begin
        tbl[0] = '{3'd0, 1'b0, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00F0_0034, 2'd1};
        tbl[1] = '{3'd1, 1'b0, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFFF0_12FF, 2'd1};
        tbl[2] = '{3'd2, 1'b0, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hFF00_12CB, 2'd1};
        tbl[3] = '{3'd3, 1'b0, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h000F_ED00, 2'd1};
        tbl[4] = '{3'd4, 1'b0, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hF000_1200, 2'd1};
        tbl[5] = '{3'd5, 1'b0, 32'hF0F0_1234, 32'h0FF0_00FF, 32'hF0FF_FF34, 2'd1};
        tbl[6] = '{3'd6, 1'b0, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h00FF_ED34, 2'd1};
        tbl[7] = '{3'd0, 1'b1, 32'h0000_1234, 32'hFFFF_EDCB, 32'h0000_0000, 2'd1};
        tbl[8] = '{3'd3, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 2'd1};
        tbl[9] = '{3'd7, 1'b1, 32'h0000_00A5, 32'hFFFF_FFFF, 32'h0000_00A5, 2'd1};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op        = '0;
        last      = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_c", 64'(c), 64'd0);
        check("rst_zero", 64'(zero), 64'd1);
        check("rst_beats", 64'(beats), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Op sweep, back to back
        for (int i = 0; i < 10; i++)
            send(tbl[i].op, tbl[i].last, tbl[i].a, tbl[i].b, 1'b1, tbl[i].ec, tbl[i].eb, 1'b1);
        drain();

        // Three-beat OR-accumulate burst
        send(3'd7, 1'b0, 32'h1, 32'h0, 1'b0, '0, '0, 1'b0);
        send(3'd7, 1'b0, 32'h10, 32'h0, 1'b0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        check("acc_no_early_output", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        send(3'd7, 1'b1, 32'h100, 32'h0, 1'b1, 32'h111, 2'd3, 1'b1);
        drain();

        // Backpressure: four OR beats against a 5-cycle stall
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(3'd1, 1'b0, 32'h100 << i, 32'h1, 1'b1, (32'h100 << i) | 32'h1, 2'd1, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                for (int i = 0; i < 5; i++) begin
                    if (i != 0) @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_out_valid", 64'(out_valid), 64'd1);
                    check("stall_c", 64'(c), 64'h101);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Interleave an AND into a burst that saturates the 2-bit counter
        send(3'd7, 1'b0, 32'h0, 32'h0, 1'b0, '0, '0, 1'b0);
        send(3'd7, 1'b0, 32'h0, 32'h0, 1'b0, '0, '0, 1'b0);
        send(3'd0, 1'b0, 32'hFF, 32'h0F, 1'b1, 32'h0F, 2'd1, 1'b1);
        send(3'd7, 1'b0, 32'h0, 32'h0, 1'b0, '0, '0, 1'b0);
        send(3'd7, 1'b0, 32'h0, 32'h0, 1'b0, '0, '0, 1'b0);
        send(3'd7, 1'b1, 32'h0, 32'h0, 1'b1, 32'h0, 2'd3, 1'b1);
        drain();

        // Flush mid-burst with a held result and a beat presented
        send(3'd7, 1'b0, 32'h8, 32'h0, 1'b0, '0, '0, 1'b0);
        send(3'd7, 1'b0, 32'h4, 32'h0, 1'b0, '0, '0, 1'b0);
        out_ready = 1'b0;
        send(3'd1, 1'b0, 32'h55, 32'hAA0, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        op       = 3'd1;
        last     = 1'b0;
        a        = 32'hDEAD_0000;
        b        = 32'h1;
        @(negedge clk);
        check("preflush_out_valid", 64'(out_valid), 64'd1);
        check("preflush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_c", 64'(c), 64'd0);
        check("flush_zero", 64'(zero), 64'd1);
        check("flush_beats", 64'(beats), 64'd0);
        @(posedge clk);
        #1;
        send(3'd7, 1'b1, 32'h1, 32'h0, 1'b1, 32'h1, 2'd1, 1'b1);
        drain();

        // Asynchronous reset while a result is stalled
        out_ready = 1'b0;
        send(3'd1, 1'b0, 32'h3, 32'h30, 1'b0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        check("prereset_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_c", 64'(c), 64'd0);
        check("arst_zero", 64'(zero), 64'd1);
        check("arst_beats", 64'(beats), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send(3'd2, 1'b0, 32'hF0, 32'hFF, 1'b1, 32'h0F, 2'd1, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit for the CPU execute path. It is the generalised successor to the fixed 32-bit combinational OR.
- Supports eight bitwise operations, including an OR-accumulate mode that reduces a burst of operands into one result.
- Uses valid/ready handshakes on both sides, has a fixed 2-cycle latency, and applies full backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 1).
- CNT_W, 8, width of the accumulate beat counter (>= 1).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous clear of pipeline and accumulator
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o
- op_i  in  3  0 AND, 1 OR, 2 XOR, 3 NOR, 4 ANDN (a&~b), 5 ORN (a|~b), 6 XNOR, 7 ACC_OR
- last_i  in  1  closes an ACC_OR burst; ignored for ops 0-6
- a_i  in  WIDTH  operand A
- b_i  in  WIDTH  operand B; ignored for ACC_OR
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result consumed when out_valid_o && out_ready_i
- c_o  out  WIDTH  result
- zero_o  out  1  c_o == 0
- beats_o  out  CNT_W  ACC_OR: number of beats reduced, saturating at 2^CNT_W-1; ops 0-6: 1

Behaviour:
- Reset (async assert, sync release): in_ready_o=1, out_valid_o=0, c_o=0, zero_o=1, beats_o=0. Both stage valids are 0. Accumulator is 0 and closed.
- Stage 1 (S1) registers op, last, a and b on an accepted beat.
- Stage 2 (S2) registers the computed result, zero flag and beat count into the output registers.
- Advance rules:
  - S2 loads when S1 is valid and (!out_valid_o || out_ready_i).
  - S1 loads when accepted.
  - in_ready_o = !s1_valid || s2_can_load. This is combinational from out_ready_i. No combinational path from in_valid_i to out_*.
- Latency: a beat accepted at edge N gives out_valid_o high after edge N+1 when no stall. Throughput is 1 beat/cycle with out_ready_i held high.
- Stall: while out_valid_o && !out_ready_i, c_o, zero_o and beats_o hold stable. S1 holds. in_ready_o=0 if S1 is valid.
- ACC_OR:
  - On S1→S2 transfer, acc_next = acc | a and cnt_next = sat(cnt+1).
  - If last=0: acc and cnt are updated, and no output is produced. S1 empties, and out_valid_o is unchanged by this beat.
  - If last=1: c_o=acc_next, beats_o=cnt_next and out_valid_o=1. Then acc=0 and cnt=0.
  - A single-beat burst (last=1 on the first beat) outputs a with beats_o=1.
- Interleaving: an op 0-6 beat during an open burst is processed normally. The accumulator and counter are untouched, and the burst continues.
- Counter saturation: cnt stops at all-ones. The accumulation itself continues.
- flush_i:
  - Clears S1 valid, out_valid_o, acc and cnt on the next edge.
  - Any beat presented in the same cycle is dropped, even if in_ready_o was 1.
  - c_o, zero_o and beats_o go to reset values.
  - in_ready_o=1 in the cycle after flush.
- Simultaneous output consume and S2 load in the same cycle is allowed, giving back-to-back results.
- Reset mid-burst or mid-stall discards all state immediately. There is no partial output.
- WIDTH=1 must elaborate and behave identically, bit-wise.

Test Plan:
- Op sweep, WIDTH=32, a=0xF0F0_1234, b=0x0FF0_00FF, out_ready_i=1:
  - Expect AND 0x00F0_0034, OR 0xFFF0_12FF, XOR 0xFF00_12CB, NOR 0x000F_ED00.
  - Expect ANDN 0xF000_1200, ORN 0xF0FF_FF34, XNOR 0x00FF_ED34.
  - Each result appears 2 cycles after accept.
- Accumulate: ACC_OR beats a=0x1, 0x10, 0x100, last on the third → one output: c_o=0x111, beats_o=3, zero_o=0. No output for the first two beats.
- Backpressure:
  - Stream 4 OR beats with out_ready_i=0 for 5 cycles.
  - Expect in_ready_o=0 after 2 beats are held, and c_o stable.
  - On release, results arrive in order with no loss or duplication.
- Interleave and saturation:
  - CNT_W=2: ACC_OR 5 beats of a=0.
  - Mid-burst, inject AND 0xFF&0x0F → 0x0F output.
  - Final burst output c_o=0, zero_o=1, beats_o=3.
- Flush mid-burst:
  - Two ACC_OR non-last beats (0x8, 0x4), then flush_i.
  - Then ACC_OR last a=0x1 → c_o=0x1, beats_o=1.
- Async reset asserted during a stalled valid output → all outputs reach reset values without a clock edge. After release, the first new beat completes normally.
